// File: rtl/rsa_pkg.sv
// Shared types and sizing for the RSA job arbiter.
// State encoding, requester count, core-reset length and watchdog limit.
package rsa_pkg;

    localparam int NUM_REQ    = 2;
    localparam int CLR_CYCLES = 2;
    localparam int CLR_W      = $clog2(CLR_CYCLES);
    localparam int WDOG_LIMIT = 200;
    localparam int WDOG_W     = 8;
    localparam int EXP_W      = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rsa_job_arbiter_if.sv
// Requester and exponentiation-core signals of the RSA job arbiter.
// slave = arbiter side, master = requesters/core side.
interface rsa_job_arbiter_if
    import rsa_pkg::*;
();

    logic [NUM_REQ-1:0] req;
    logic [EXP_W-1:0]   exp0;
    logic [EXP_W-1:0]   exp1;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] err;
    logic               busy;
    logic               core_rstb;
    logic               core_en;
    logic [EXP_W-1:0]   core_exp;
    logic               core_eoc;

    modport slave (
        input  req, exp0, exp1, core_eoc,
        output gnt, done, err, busy,
        output core_rstb, core_en, core_exp
    );

    modport master (
        output req, exp0, exp1, core_eoc,
        input  gnt, done, err, busy,
        input  core_rstb, core_en, core_exp
    );

endinterface

// File: rtl/rsa_job_arbiter_rr.sv
// Two-way round-robin winner select with last-granted pointer.
// Pointer resets to requester 1 so requester 0 wins the first tie.
module rr_arbiter2
    import rsa_pkg::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic [NUM_REQ-1:0] req,
    input  logic               load,
    output logic               win,
    output logic               any
);

    logic last;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            last <= 1'b1;
        else if (load && any)
            last <= win;
    end

    always_comb begin
        win = 1'b0;
        any = |req;
        unique case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
    end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Arbitrates two requesters onto one exponentiation core and sequences it.
// Define RSA_ARB_WATCHDOG_EN to add the RUN-cycle watchdog abort.
module rsa_job_arbiter
    import rsa_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    rsa_job_arbiter_if.slave bus
);

    state_t             state;
    state_t             state_nxt;
    logic               owner;
    logic [EXP_W-1:0]   exp_q;
    logic [CLR_W-1:0]   clr_cnt;
    logic               win;
    logic               any;
    logic               grant;
    logic               wd_hit;
    logic               abort_q;

    assign grant = (state == IDLE) && any;

    rr_arbiter2 u_rr (
        .clk  (clk),
        .rstb (rstb),
        .req  (bus.req),
        .load (grant),
        .win  (win),
        .any  (any)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (any) state_nxt = CLR;
            CLR:  if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) state_nxt = RUN;
            RUN:  if (bus.core_eoc || wd_hit) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            owner <= 1'b0;
            exp_q <= '0;
        end else if (grant) begin
            owner <= win;
            exp_q <= win ? bus.exp1 : bus.exp0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            clr_cnt <= '0;
        else if (state == CLR)
            clr_cnt <= clr_cnt + 1'b1;
        else
            clr_cnt <= '0;
    end

`ifdef RSA_ARB_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            wdog <= '0;
        else if (state == RUN)
            wdog <= wdog + 1'b1;
        else
            wdog <= '0;
    end

    // Timeout only counts when eoc did not arrive in the same cycle.
    assign wd_hit = (state == RUN) && (wdog == WDOG_W'(WDOG_LIMIT - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            abort_q <= 1'b0;
        else if (state == RUN)
            abort_q <= wd_hit && !bus.core_eoc;
    end
`else
    assign wd_hit  = 1'b0;
    assign abort_q = 1'b0;
`endif

    always_comb begin
        bus.gnt       = '0;
        bus.done      = '0;
        bus.err       = '0;
        bus.busy      = (state != IDLE);
        bus.core_rstb = (state == RUN);
        bus.core_en   = (state == RUN);
        bus.core_exp  = exp_q;
        if (state == CLR || state == RUN)
            bus.gnt = onehot(owner);
        if (state == FIN) begin
            if (abort_q)
                bus.err = onehot(owner);
            else
                bus.done = onehot(owner);
        end
    end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Randomized job-level bench for rsa_job_arbiter with a round-robin model.
// Honours RSA_ARB_WATCHDOG_EN to predict watchdog aborts.
module tb_rsa_job_arbiter;

    logic clk = 1'b0;
    logic rstb;

    always #5 clk = ~clk;

    rsa_job_arbiter_if bus ();

    rsa_job_arbiter dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

`ifdef RSA_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int last_gnt = 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic chk_out(input string ph, input logic [1:0] g,
                           input logic [1:0] d, input logic [1:0] e,
                           input logic b, input logic en, input logic cr);
        chk({ph, ".gnt"},       bus.gnt,       g);
        chk({ph, ".done"},      bus.done,      d);
        chk({ph, ".err"},       bus.err,       e);
        chk({ph, ".busy"},      bus.busy,      b);
        chk({ph, ".core_en"},   bus.core_en,   en);
        chk({ph, ".core_rstb"}, bus.core_rstb, cr);
    endtask

    // Starts at a negedge with the DUT idle; ends at a negedge, DUT idle.
    task automatic job(input logic [1:0] r, input logic [9:0] e0,
                       input logic [9:0] e1, input int delay,
                       input bit keep, input bit drop, input int abort_at);
        int w;
        logic [1:0] oh;
        logic [9:0] ew;
        bit to;
        int run_len;
        bus.req  = r;
        bus.exp0 = e0;
        bus.exp1 = e1;
        bus.core_eoc = 1'($urandom_range(0, 1));
        if (r == 2'b01)      w = 0;
        else if (r == 2'b10) w = 1;
        else                 w = (last_gnt == 1) ? 0 : 1;
        last_gnt = w;
        oh = (w == 1) ? 2'b10 : 2'b01;
        ew = (w == 1) ? e1 : e0;
        to = WD && (delay > 200);
        run_len = to ? 200 : delay;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_out("clr", oh, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
            chk("clr.core_exp", bus.core_exp, ew);
            bus.exp0 = 10'($urandom);
            bus.exp1 = 10'($urandom);
            bus.core_eoc = 1'($urandom_range(0, 1));
        end
        for (int k = 1; k <= run_len; k++) begin
            @(negedge clk);
            chk_out("run", oh, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1);
            chk("run.core_exp", bus.core_exp, ew);
            if (drop && k == (run_len + 1) / 2) begin
                bus.req  = 2'b00;
                bus.exp0 = ~e0;
                bus.exp1 = ~e1;
            end
            if (abort_at == k) begin
                rstb = 1'b0;
                bus.req = 2'b00;
                bus.core_eoc = 1'b1;
                #1;
                chk_out("rst", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
                chk("rst.core_exp", bus.core_exp, 0);
                last_gnt = 1;
                repeat (3) begin
                    @(negedge clk);
                    chk_out("rsthold", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
                end
                rstb = 1'b1;
                bus.core_eoc = 1'b0;
                return;
            end
            bus.core_eoc = (k == delay);
        end
        @(negedge clk);
        chk_out("fin", 2'b00, to ? 2'b00 : oh, to ? oh : 2'b00,
                1'b1, 1'b0, 1'b0);
        bus.core_eoc = 1'($urandom_range(0, 1));
        if (!keep) bus.req = 2'b00;
        @(negedge clk);
        chk_out("idle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        bus.core_eoc = 1'b0;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        bus.req = 2'b00;
        bus.core_eoc = 1'b0;
        last_gnt = 1;
        repeat (2) @(negedge clk);
        chk_out("reset", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("reset.core_exp", bus.core_exp, 0);
        rstb = 1'b1;
        @(negedge clk);
        chk_out("post_reset", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int d;
        bus.exp0 = '0;
        bus.exp1 = '0;
        do_reset();

        job(2'b01, 10'h2A5, 10'h111, 134, 1'b0, 1'b0, 0);

        do_reset();
        job(2'b11, 10'h0F0, 10'h30F, 20, 1'b1, 1'b0, 0);
        job(2'b11, 10'h155, 10'h2AA, 15, 1'b0, 1'b0, 0);

        job(2'b01, 10'h3C3, 10'h001, 60, 1'b0, 1'b1, 0);

        job(2'b10, 10'h010, 10'h123, 250, 1'b0, 1'b0, 0);
        job(2'b01, 10'h020, 10'h321, 200, 1'b0, 1'b0, 0);
        job(2'b10, 10'h030, 10'h3FF, 199, 1'b0, 1'b0, 0);

        job(2'b11, 10'h044, 10'h088, 100, 1'b0, 1'b0, 40);
        job(2'b11, 10'h099, 10'h0AA, 5, 1'b0, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(150, 230)
                                              : $urandom_range(1, 40);
            job(2'($urandom_range(1, 3)), 10'($urandom), 10'($urandom), d,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? $urandom_range(1, d) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
